// File: rtl/conv_pkg.sv
// conv_pkg: shared types, default widths and helpers for the convolution sequencer.
// Rev 1.0
`default_nettype none

package conv_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_OUT_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    READ   = 3'd2,
    DRAIN  = 3'd3,
    WRITE  = 3'd4,
    FINISH = 3'd5
  } state_t;

  // A full-length sum of 2^addr_w maximal products cannot wrap at this width.
  function automatic int acc_width(input int data_w, input int addr_w);
    return 2 * data_w + addr_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_mac.sv
// conv_mac: registered multiply-accumulate with clear, delayed valid and OUT_W overflow flag.
// Rev 1.0
`default_nettype none

module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OUT_W  = DEF_OUT_W,
  localparam int ACC_W = acc_width(DATA_W, ADDR_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic              over
);

  logic                  valid_q;
  logic [2*DATA_W-1:0]   product;

  assign product = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  // Read data arrives one cycle after the strobe, so the valid is delayed to match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      acc     <= '0;
    end else begin
      valid_q <= in_valid;
      if (clear)
        acc <= '0;
      else if (valid_q)
        acc <= acc + {{ADDR_W{1'b0}}, product};
    end
  end

  assign over = |acc[ACC_W-1:OUT_W];

endmodule

`default_nettype wire

// File: rtl/conv_sequencer.sv
// conv_sequencer: sequences a full 1-D convolution over memX/memY into memZ.
// Rev 1.0
`default_nettype none

module conv_sequencer
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   sizeX,
  input  logic [ADDR_W:0]   sizeY,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ovf,
  output logic              memX_rd,
  output logic [ADDR_W-1:0] memX_addr,
  input  logic [DATA_W-1:0] memX_data,
  output logic              memY_rd,
  output logic [ADDR_W-1:0] memY_addr,
  input  logic [DATA_W-1:0] memY_data,
  output logic              memZ_we,
  output logic [ADDR_W:0]   memZ_addr,
  output logic [OUT_W-1:0]  memZ_data
);

  localparam int ACC_W = acc_width(DATA_W, ADDR_W);
  localparam int CNT_W = ADDR_W + 1;
  localparam int SUM_W = ADDR_W + 2;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   size_x, size_y;
  logic [CNT_W-1:0]   n, k, k_hi;
  logic               ovf_q, err_q;
  logic [ACC_W-1:0]   acc;
  logic               acc_over;
  logic [SUM_W-1:0]   last_n;
  logic [CNT_W-1:0]   k_lo_calc, k_hi_calc;
  logic [ADDR_W-1:0]  x_idx;
  logic               is_last, size_zero;

  assign size_zero = (sizeX == '0) || (sizeY == '0);
  assign last_n    = {1'b0, size_x} + {1'b0, size_y} - SUM_W'(2);
  assign is_last   = ({1'b0, n} == last_n);

  // Term range for output n: k in [max(0, n-sizeX+1), min(n, sizeY-1)].
  assign k_lo_calc = (n >= size_x) ? (n - size_x + CNT_W'(1)) : '0;
  assign k_hi_calc = (n < size_y) ? n : (size_y - CNT_W'(1));
  assign x_idx     = ADDR_W'(n - k);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      size_x <= '0;
      size_y <= '0;
      n      <= '0;
      k      <= '0;
      k_hi   <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            size_x <= sizeX;
            size_y <= sizeY;
            ovf_q  <= 1'b0;
            err_q  <= size_zero;
            n      <= '0;
          end
        end
        SETUP: begin
          k    <= k_lo_calc;
          k_hi <= k_hi_calc;
        end
        READ:  k <= k + CNT_W'(1);
        WRITE: begin
          if (acc_over)
            ovf_q <= 1'b1;
          if (!is_last)
            n <= n + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    done      = 1'b0;
    err       = 1'b0;
    ovf       = 1'b0;
    memX_rd   = 1'b0;
    memX_addr = '0;
    memY_rd   = 1'b0;
    memY_addr = '0;
    memZ_we   = 1'b0;
    memZ_addr = '0;
    memZ_data = '0;
    case (state)
      IDLE: begin
        if (start)
          state_nx = size_zero ? FINISH : SETUP;
      end
      SETUP: state_nx = READ;
      READ: begin
        memX_rd   = 1'b1;
        memY_rd   = 1'b1;
        memX_addr = x_idx;
        memY_addr = k[ADDR_W-1:0];
        if (k == k_hi)
          state_nx = DRAIN;
      end
      DRAIN: state_nx = WRITE;
      WRITE: begin
        memZ_we   = 1'b1;
        memZ_addr = n;
        memZ_data = acc[OUT_W-1:0];
        state_nx  = is_last ? FINISH : SETUP;
      end
      FINISH: begin
        done     = 1'b1;
        err      = err_q;
        ovf      = ovf_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  conv_mac #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .OUT_W  (OUT_W)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == SETUP),
    .in_valid (memX_rd),
    .a        (memX_data),
    .b        (memY_data),
    .acc      (acc),
    .over     (acc_over)
  );

endmodule

`default_nettype wire

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed scoreboard bench for conv_sequencer.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_conv_sequencer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int OUT_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   sizeX = '0;
  logic [ADDR_W:0]   sizeY = '0;
  logic              busy, done, err, ovf;
  logic              memX_rd, memY_rd, memZ_we;
  logic [ADDR_W-1:0] memX_addr, memY_addr;
  logic [DATA_W-1:0] memX_data = '0;
  logic [DATA_W-1:0] memY_data = '0;
  logic [ADDR_W:0]   memZ_addr;
  logic [OUT_W-1:0]  memZ_data;

  logic [DATA_W-1:0] xmem [0:31];
  logic [DATA_W-1:0] ymem [0:31];

  typedef struct { int cyc; int addr; int data; } wr_t;
  typedef struct { int cyc; bit err; bit ovf; } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int strobes = 0;
  int writes = 0;
  int dones = 0;

  conv_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .sizeX(sizeX), .sizeY(sizeY),
    .busy(busy), .done(done), .err(err), .ovf(ovf),
    .memX_rd(memX_rd), .memX_addr(memX_addr), .memX_data(memX_data),
    .memY_rd(memY_rd), .memY_addr(memY_addr), .memY_data(memY_data),
    .memZ_we(memZ_we), .memZ_addr(memZ_addr), .memZ_data(memZ_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memories: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (memX_rd) memX_data <= xmem[memX_addr];
    if (memY_rd) memY_data <= ymem[memY_addr];
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expected writes/completions as the DUT presents them.
  always @(negedge clk) begin
    if (memX_rd || memY_rd) strobes++;
    if (memZ_we) begin
      wr_t e;
      writes++;
      if (wq.size() == 0) begin
        check("unexpected_write_addr", memZ_addr, -1);
      end else begin
        e = wq.pop_front();
        check("wr_addr", memZ_addr, e.addr);
        check("wr_data", memZ_data, e.data);
        if (e.cyc >= 0) check("wr_cycle", cyc, e.cyc);
      end
    end
    if (done) begin
      dn_t d;
      dones++;
      if (dq.size() == 0) begin
        check("unexpected_done_cycle", cyc, -1);
      end else begin
        d = dq.pop_front();
        check("done_cycle", cyc, d.cyc);
        check("done_busy", busy, 1);
        check("done_err", err, d.err);
        check("done_ovf", ovf, d.ovf);
      end
    end
  end

  task automatic push_wr(input int c, input int a, input int d);
    wr_t e;
    e.cyc = c; e.addr = a; e.data = d;
    wq.push_back(e);
  endtask

  task automatic push_done(input int c, input bit e, input bit o);
    dn_t d;
    d.cyc = c; d.err = e; d.ovf = o;
    dq.push_back(d);
  endtask

  // Drives the command in the current cycle; caller pushes expectations then drops start.
  task automatic issue(input int sx, input int sy, output int c0);
    @(negedge clk);
    c0    = cyc;
    sizeX = (ADDR_W+1)'(sx);
    sizeY = (ADDR_W+1)'(sy);
    start = 1'b1;
  endtask

  task automatic finish_job(input string name, input int d0);
    int n = 0;
    while (dones == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, dones - d0, 1);
    @(posedge clk);
    #1;
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_pending"}, wq.size() + dq.size(), 0);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({busy, done, err, ovf, memX_rd, memX_addr, memY_rd, memY_addr,
                memZ_we, memZ_addr, memZ_data});
  endfunction

  task automatic load_s1();
    xmem[0] = 8'd1; xmem[1] = 8'd2; xmem[2] = 8'd3;
    ymem[0] = 8'd4; ymem[1] = 8'd5;
  endtask

  task automatic run_s1(input string name);
    int c0, d0;
    load_s1();
    d0 = dones;
    issue(3, 2, c0);
    push_wr(c0 + 4, 0, 4);
    push_wr(c0 + 9, 1, 13);
    push_wr(c0 + 14, 2, 22);
    push_wr(c0 + 18, 3, 15);
    push_done(c0 + 19, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    finish_job(name, d0);
  endtask

  initial begin
    int c0, d0, s0, w0, n;
    bit busy_ok;

    for (int i = 0; i < 32; i++) begin
      xmem[i] = '0;
      ymem[i] = '0;
    end

    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_s1("s1");

    // 255x255 twice with start held high throughout the job and its done cycle.
    xmem[0] = 8'd255; xmem[1] = 8'd255;
    ymem[0] = 8'd255; ymem[1] = 8'd255;
    d0 = dones;
    issue(2, 2, c0);
    push_wr(c0 + 4, 0, 65025);
    push_wr(c0 + 9, 1, 64514);
    push_wr(c0 + 13, 2, 65025);
    push_done(c0 + 14, 1'b0, 1'b1);
    busy_ok = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!busy) busy_ok = 1'b0;
    end while (!done && n < 100);
    check("pulse_done_seen", done, 1);
    @(negedge clk);
    start = 1'b0;
    check("pulse_busy_held", busy_ok, 1);
    busy_ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (busy) busy_ok = 1'b0;
    end
    check("pulse_no_restart", busy_ok, 1);
    check("pulse_one_done", dones - d0, 1);

    // Single-term job; also shows ovf cleared by the new start.
    xmem[0] = 8'd7; ymem[0] = 8'd9;
    d0 = dones;
    issue(1, 1, c0);
    push_wr(c0 + 4, 0, 63);
    push_done(c0 + 5, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    finish_job("s2", d0);

    // Zero size: no memory traffic, immediate err completion.
    d0 = dones; s0 = strobes; w0 = writes;
    issue(3, 0, c0);
    push_done(c0 + 1, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    finish_job("s4", d0);
    check("s4_no_reads", strobes - s0, 0);
    check("s4_no_writes", writes - w0, 0);

    // Asynchronous reset during the first READ of n=2.
    load_s1();
    issue(3, 2, c0);
    push_wr(c0 + 4, 0, 4);
    push_wr(c0 + 9, 1, 13);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (cyc < c0 + 11 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_in_read", memX_rd, 1);
    d0 = dones; w0 = writes;
    #2 reset = 1'b0;
    #1 check("abort_outputs_zero", out_vec(), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_writes", writes - w0, 0);
    check("abort_no_done", dones - d0, 0);
    check("abort_idle", busy, 0);
    check("abort_queue_drained", wq.size(), 0);

    run_s1("s1_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
